// File: rtl/fert_pkg.sv
// fert_pkg: shared state encoding, default sizes and index-width helper for the fertilizer scheduler
package fert_pkg;
  typedef enum logic [1:0] {IDLE, DOSING, EMPTY} state_t;
  localparam int N_CH_DEF   = 4;
  localparam int DOSE_W_DEF = 16;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req at or after ptr (req/ptr in, gnt_idx/gnt_valid out)
module rr_arbiter
  import fert_pkg::*;
#(
  parameter int N = N_CH_DEF
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [clog2(N)-1:0]   gnt_idx,
  output logic                  gnt_valid
);
  localparam int W = clog2(N);
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt_idx   = W'((int'(ptr) + k) % N);
        gnt_valid = 1'b1;
      end
  end
endmodule

// File: rtl/fertilizing_scheduler.sv
// fertilizing_scheduler: shares one injector among N_CH zones, meters dose_len active cycles per grant (aspersao/b_adb/vazio/dose_len in, mist_adb/adubou/busy/fault_empty out)
module fertilizing_scheduler
  import fert_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DOSE_W = DOSE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   aspersao,
  input  logic [N_CH-1:0]   b_adb,
  input  logic              vazio,
  input  logic [DOSE_W-1:0] dose_len,
  output logic [N_CH-1:0]   mist_adb,
  output logic [N_CH-1:0]   adubou,
  output logic              busy,
  output logic              fault_empty
);
  localparam int W = clog2(N_CH);
  state_t            r_state, w_next;
  logic [W-1:0]      r_g, r_ptr, w_gi;
  logic [DOSE_W-1:0] r_len, r_cnt;
  logic [N_CH-1:0]   r_adubou, w_set, w_req;
  logic              w_gv, w_grant, w_adv, w_asp, w_last;
  assign w_req  = aspersao & ~b_adb & ~r_adubou;
  assign w_asp  = aspersao[r_g];
  assign w_last = r_cnt == r_len - DOSE_W'(1);
  assign adubou = r_adubou;
  rr_arbiter #(.N(N_CH)) u_arb (
    .req      (w_req),
    .ptr      (r_ptr),
    .gnt_idx  (w_gi),
    .gnt_valid(w_gv)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next  = r_state;
    w_set   = '0;
    w_grant = 1'b0;
    w_adv   = 1'b0;
    case (r_state)
      IDLE:
        if (w_gv && !vazio) begin
          w_grant = 1'b1;
          if (dose_len == '0) w_set[w_gi] = 1'b1;
          else                w_next = DOSING;
        end
      DOSING:
        if (vazio) w_next = EMPTY;
        else if (!w_asp) begin
          w_next = IDLE;
          w_adv  = 1'b1;
        end else if (w_last) begin
          w_next     = IDLE;
          w_adv      = 1'b1;
          w_set[r_g] = 1'b1;
        end
      EMPTY:
        if (!w_asp) begin
          w_next = IDLE;
          w_adv  = 1'b1;
        end else if (!vazio) w_next = DOSING;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_g      <= '0;
      r_ptr    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_adubou <= '0;
    end else begin
      r_g      <= w_grant ? w_gi : r_g;
      r_len    <= w_grant ? dose_len : r_len;
      r_ptr    <= !w_adv ? r_ptr : (r_g == W'(N_CH - 1)) ? '0 : r_g + W'(1);
      r_cnt    <= (w_grant || w_adv) ? '0 : (r_state == DOSING && !vazio) ? r_cnt + DOSE_W'(1) : r_cnt;
      // a zone whose sprinkler is off re-arms; this also beats a same-cycle set
      r_adubou <= (r_adubou | w_set) & aspersao;
    end
  always_comb begin
    mist_adb      = '0;
    mist_adb[r_g] = (r_state == DOSING) && !vazio && w_asp;
    busy          = r_state != IDLE;
    fault_empty   = r_state == EMPTY;
  end
endmodule

// File: tb/tb_fertilizing_scheduler.sv
// tb_fertilizing_scheduler: table-driven and sequence checks of the fertilizer scheduler
module tb_fertilizing_scheduler;
  logic        clk, reset, vazio;
  logic [3:0]  aspersao, b_adb, mist_adb, adubou;
  logic [15:0] dose_len;
  logic        busy, fault_empty;
  int n_chk = 0, n_err = 0;
  int valve, faults, bad, vz;
  typedef struct {
    logic        rst;
    logic [3:0]  asp, badb;
    logic        vz;
    logic [15:0] len;
    logic [3:0]  e_mist, e_ad;
    logic        e_busy, e_fault;
  } vec_t;
  vec_t tbl[$];
  fertilizing_scheduler #(.N_CH(4), .DOSE_W(16)) dut (
    .clk(clk), .reset(reset), .aspersao(aspersao), .b_adb(b_adb), .vazio(vazio),
    .dose_len(dose_len), .mist_adb(mist_adb), .adubou(adubou), .busy(busy), .fault_empty(fault_empty)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic rst, input logic [3:0] asp, input logic [15:0] len,
                     input logic [3:0] e_mist, input logic [3:0] e_ad, input logic e_busy);
    vec_t v;
    v.rst = rst; v.asp = asp; v.badb = 4'b0; v.vz = 1'b0; v.len = len;
    v.e_mist = e_mist; v.e_ad = e_ad; v.e_busy = e_busy; v.e_fault = 1'b0;
    tbl.push_back(v);
  endtask
  task automatic pulse_reset();
    reset = 1; #1; reset = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1; aspersao = 0; b_adb = 0; vazio = 0; dose_len = 0;
    #1;
    chk("reset mist", mist_adb, 0);
    chk("reset adubou", adubou, 0);
    chk("reset busy", busy, 0);
    chk("reset fault", fault_empty, 0);
    @(posedge clk); #1; reset = 0;
    // single zone, dose_len 5
    add(1, 4'b0100, 5, 4'b0100, 4'b0000, 1);
    for (int i = 0; i < 4; i++) add(0, 4'b0100, 5, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, 5, 4'b0000, 4'b0100, 0);
    add(0, 4'b0100, 5, 4'b0000, 4'b0100, 0);
    add(0, 4'b0000, 5, 4'b0000, 4'b0000, 0);
    // round robin over zones 0,1,3 with dose_len 3
    add(1, 4'b1011, 3, 4'b0001, 4'b0000, 1);
    add(0, 4'b1011, 3, 4'b0001, 4'b0000, 1);
    add(0, 4'b1011, 3, 4'b0001, 4'b0000, 1);
    add(0, 4'b1011, 3, 4'b0000, 4'b0001, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 3, 4'b0010, 4'b0001, 1);
    add(0, 4'b1011, 3, 4'b0000, 4'b0011, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 3, 4'b1000, 4'b0011, 1);
    add(0, 4'b1011, 3, 4'b0000, 4'b1011, 0);
    add(0, 4'b1011, 3, 4'b0000, 4'b1011, 0);
    add(0, 4'b1011, 3, 4'b0000, 4'b1011, 0);
    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      aspersao = tbl[i].asp; b_adb = tbl[i].badb; vazio = tbl[i].vz; dose_len = tbl[i].len;
      @(posedge clk); #1;
      chk($sformatf("row%0d mist", i), mist_adb, tbl[i].e_mist);
      chk($sformatf("row%0d adubou", i), adubou, tbl[i].e_ad);
      chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("row%0d fault", i), fault_empty, tbl[i].e_fault);
    end
    // tank empty after 4 valve cycles for 6 cycles, dose_len 10
    pulse_reset();
    aspersao = 4'b0100; b_adb = 0; vazio = 0; dose_len = 10;
    valve = 0; faults = 0; bad = 0; vz = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      vazio = (valve >= 4 && vz < 6);
      @(negedge clk);
      if (vazio) begin
        vz++;
        if (mist_adb != 0) bad++;
      end
      if (mist_adb == 4'b0100) valve++;
      if (fault_empty) faults++;
    end
    chk("empty valve total", valve, 10);
    chk("empty fault cycles", faults, 6);
    chk("empty mist leak", bad, 0);
    chk("empty adubou", adubou, 4'b0100);
    chk("empty busy", busy, 0);
    // abort after 2 valve cycles, then fresh full dose
    pulse_reset();
    aspersao = 4'b0010; dose_len = 8; valve = 0;
    for (int c = 0; c < 10 && valve < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (mist_adb == 4'b0010) valve++;
    end
    chk("abort pre valve", valve, 2);
    @(posedge clk); #1; aspersao = 4'b0000;
    @(posedge clk); #1;
    chk("abort busy", busy, 0);
    chk("abort adubou", adubou, 0);
    chk("abort mist", mist_adb, 0);
    aspersao = 4'b0010; valve = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (mist_adb == 4'b0010) valve++;
    end
    chk("redose valve", valve, 8);
    chk("redose adubou", adubou, 4'b0010);
    chk("redose busy", busy, 0);
    // inhibit, zero length, adubou clear
    pulse_reset();
    aspersao = 4'b0001; b_adb = 4'b0001; dose_len = 3; bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (mist_adb != 0 || busy) bad++;
    end
    chk("inhibit no grant", bad, 0);
    chk("inhibit adubou", adubou, 0);
    aspersao = 4'b0101; dose_len = 0; bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (mist_adb != 0 || busy) bad++;
    end
    chk("zero len no valve", bad, 0);
    chk("zero len adubou", adubou, 4'b0100);
    aspersao = 4'b0001;
    #1;
    chk("clear before edge", adubou, 4'b0100);
    @(posedge clk); #1;
    chk("clear after edge", adubou, 4'b0000);
    // async reset during a dose
    pulse_reset();
    b_adb = 0; aspersao = 4'b1001; dose_len = 1;
    for (int c = 0; c < 10 && adubou != 4'b0001; c++) begin
      @(posedge clk); #1;
    end
    chk("pre reset adubou", adubou, 4'b0001);
    dose_len = 20;
    for (int c = 0; c < 5 && mist_adb != 4'b1000; c++) begin
      @(posedge clk); #1;
    end
    chk("pre reset mist", mist_adb, 4'b1000);
    chk("pre reset busy", busy, 1);
    @(negedge clk); #2;
    reset = 1; #1;
    chk("async mist", mist_adb, 0);
    chk("async busy", busy, 0);
    chk("async adubou", adubou, 0);
    chk("async fault", fault_empty, 0);
    #3 reset = 0;
    chk("post reset busy", busy, 0);
    @(posedge clk); #1;
    chk("post reset ptr0 grant", mist_adb, 4'b0001);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
